// File: rtl/ex_stage_pipe_reg.sv
// ex_stage_pipe_reg: parametrised ID/EX pipeline register for the RV32IM pipeline.
// Carries a control bundle and a datapath bundle through DEPTH retiming stages,
// each stage with its own valid bit. Stall holds the chain, flush inserts bubbles,
// and the control bits of an invalid stage are always zero.
//
// Parameters: CTRL_W (control width), DATA_W (datapath width), DEPTH (1..4 stages).
// Ports:
//   CLK, RESET          rising-edge clock, synchronous active-high reset
//   stall, flush        hold all stages / kill all stages (flush wins)
//   in_valid, ctrl_in,  upstream slot and its bundles
//   data_in
//   out_valid           last stage holds a real instruction
//   ctrl_out            last-stage control, gated by out_valid
//   data_out            last-stage datapath (held, undefined when invalid)
//   occupancy           registered count of valid stages
// Optional feature macro: EX_PIPE_REG_PERF_EN adds saturating 32-bit
//   stall_cnt and bubble_cnt output ports.
module ex_stage_pipe_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 136,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [CTRL_W-1:0]            ctrl_in,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         out_valid,
  output logic [CTRL_W-1:0]            ctrl_out,
  output logic [DATA_W-1:0]            data_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef EX_PIPE_REG_PERF_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  bubble_cnt
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);
  // Array sizing stays legal even when DEPTH is rejected below.
  localparam int unsigned NS    = (DEPTH < 1) ? 1 : DEPTH;

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("ex_stage_pipe_reg: DEPTH must be in 1..4");
    end
  endgenerate

  logic [NS-1:0]     valid_q;
  logic [NS-1:0]     valid_d;
  logic [CTRL_W-1:0] ctrl_q [NS];
  logic [CTRL_W-1:0] ctrl_d [NS];
  logic [DATA_W-1:0] data_q [NS];
  logic [DATA_W-1:0] data_d [NS];
  logic [OCC_W-1:0]  occ_d;

  // Next-state for the whole chain: flush beats stall, stall beats advance.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      // Data deliberately held to avoid toggling the wide datapath.
      for (int unsigned k = 0; k < NS; k++) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end
    end else if (!stall) begin
      valid_d[0] = in_valid;
      ctrl_d[0]  = in_valid ? ctrl_in : '0;
      data_d[0]  = data_in;
      for (int unsigned k = 1; k < NS; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // Popcount of next valids so occupancy lands on the same edge as the stages.
  always_comb begin
    occ_d = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  // Stage and occupancy registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
      for (int unsigned k = 0; k < NS; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = valid_q[NS-1];
  assign data_out  = data_q[NS-1];
  // Gate keeps a bubble's control at zero even if storage were ever stale.
  assign ctrl_out  = ctrl_q[NS-1] & {CTRL_W{valid_q[NS-1]}};

`ifdef EX_PIPE_REG_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!out_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage_pipe_reg.sv
// tb_ex_stage_pipe_reg: directed bench for ex_stage_pipe_reg at DEPTH 2, 3 and 4.
// All three instances share stimulus; each scenario resets first and checks
// the instance whose depth it targets.
module tb_ex_stage_pipe_reg;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 136;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;

  logic          ov2, ov3, ov4;
  logic [CW-1:0] co2, co3, co4;
  logic [DW-1:0] do2, do3, do4;
  logic [1:0]    oc2, oc3;
  logic [2:0]    oc4;
`ifdef EX_PIPE_REG_PERF_EN
  logic [31:0]   sc2, bc2, sc3, bc3, sc4, bc4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ex_stage_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u_d2 (
    .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush),
    .in_valid(in_valid), .ctrl_in(ctrl_in), .data_in(data_in),
    .out_valid(ov2), .ctrl_out(co2), .data_out(do2), .occupancy(oc2)
`ifdef EX_PIPE_REG_PERF_EN
    , .stall_cnt(sc2), .bubble_cnt(bc2)
`endif
  );

  ex_stage_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3)) u_d3 (
    .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush),
    .in_valid(in_valid), .ctrl_in(ctrl_in), .data_in(data_in),
    .out_valid(ov3), .ctrl_out(co3), .data_out(do3), .occupancy(oc3)
`ifdef EX_PIPE_REG_PERF_EN
    , .stall_cnt(sc3), .bubble_cnt(bc3)
`endif
  );

  ex_stage_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(4)) u_d4 (
    .CLK(CLK), .RESET(RESET), .stall(stall), .flush(flush),
    .in_valid(in_valid), .ctrl_in(ctrl_in), .data_in(data_in),
    .out_valid(ov4), .ctrl_out(co4), .data_out(do4), .occupancy(oc4)
`ifdef EX_PIPE_REG_PERF_EN
    , .stall_cnt(sc4), .bubble_cnt(bc4)
`endif
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; ctrl_in = '0; data_in = '0;
    tick();
    RESET = 1'b0;
  endtask

  // Reset held two cycles with a live, all-ones input slot.
  task automatic test_reset();
    RESET = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; ctrl_in = '1; data_in = '1;
    tick();
    tick();
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", ov3); end
    total++; if (co3 !== '0) begin bad++; $display("FAIL reset_ctrl_out: got %0h want 0", co3); end
    total++; if (do3 !== '0) begin bad++; $display("FAIL reset_data_out: got %0h want 0", do3); end
    total++; if (oc3 !== 2'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", oc3); end
    total++; if ({ov2, co2, do2, oc2} !== '0) begin bad++; $display("FAIL reset_d2_outputs: got %0h want 0", {ov2, co2, do2, oc2}); end
    total++; if ({ov4, co4, do4, oc4} !== '0) begin bad++; $display("FAIL reset_d4_outputs: got %0h want 0", {ov4, co4, do4, oc4}); end
    RESET = 1'b0;
  endtask

  // Reset asserted together with stall and flush clears data too.
  task automatic test_reset_priority();
    do_reset();
    in_valid = 1'b1; ctrl_in = 16'h0005; data_in = DW'(32'h77);
    tick();
    tick();
    total++; if (do2 !== DW'(32'h77)) begin bad++; $display("FAIL rstpri_prefill: got %0h want 77", do2); end
    RESET = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    total++; if ({ov2, co2, do2, oc2} !== '0) begin bad++; $display("FAIL rstpri_d2_cleared: got %0h want 0", {ov2, co2, do2, oc2}); end
    total++; if ({ov4, co4, do4, oc4} !== '0) begin bad++; $display("FAIL rstpri_d4_cleared: got %0h want 0", {ov4, co4, do4, oc4}); end
    RESET = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  // One valid slot through DEPTH=3, bubbles behind it.
  task automatic test_latency();
    logic       ev;
    logic [1:0] eo;
    do_reset();
    in_valid = 1'b1; ctrl_in = 16'h0021; data_in = DW'(8'hA5);
    for (int c = 1; c <= 4; c++) begin
      tick();
      in_valid = 1'b0; ctrl_in = '0; data_in = '0;
      ev = (c == 3);
      eo = (c <= 3) ? 2'd1 : 2'd0;
      total++; if (ov3 !== ev) begin bad++; $display("FAIL latency_valid[c%0d]: got %0b want %0b", c, ov3, ev); end
      total++; if (oc3 !== eo) begin bad++; $display("FAIL latency_occ[c%0d]: got %0d want %0d", c, oc3, eo); end
      if (c == 3) begin
        total++; if (do3 !== DW'(8'hA5)) begin bad++; $display("FAIL latency_data: got %0h want a5", do3); end
        total++; if (co3 !== 16'h0021) begin bad++; $display("FAIL latency_ctrl: got %0h want 0021", co3); end
      end else begin
        total++; if (co3 !== '0) begin bad++; $display("FAIL latency_ctrl_idle[c%0d]: got %0h want 0", c, co3); end
      end
    end
  endtask

  // Stream 1..4 into DEPTH=2 with a 3-cycle stall after 2 enters.
  task automatic test_stall();
    logic       st  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       iv  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] din [9] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd0, 8'd0};
    logic       ev  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed  [9] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    logic [1:0] eo  [9] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
    logic [CW-1:0] ec;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      stall = st[j]; in_valid = iv[j];
      ctrl_in = 16'h0100 | CW'(din[j]);
      data_in = DW'(din[j]);
      tick();
      ec = ev[j] ? (16'h0100 | CW'(ed[j])) : '0;
      total++; if (ov2 !== ev[j]) begin bad++; $display("FAIL stall_valid[%0d]: got %0b want %0b", j, ov2, ev[j]); end
      total++; if (oc2 !== eo[j]) begin bad++; $display("FAIL stall_occ[%0d]: got %0d want %0d", j, oc2, eo[j]); end
      total++; if (co2 !== ec) begin bad++; $display("FAIL stall_ctrl[%0d]: got %0h want %0h", j, co2, ec); end
      if (ev[j]) begin
        total++; if (do2 !== DW'(ed[j])) begin bad++; $display("FAIL stall_data[%0d]: got %0h want %0h", j, do2, ed[j]); end
      end
    end
    stall = 1'b0;
  endtask

  // Full DEPTH=4 chain hit by stall+flush together.
  task automatic test_flush_vs_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; ctrl_in = CW'(i + 1); data_in = DW'(32'h10 + i);
      tick();
    end
    total++; if (oc4 !== 3'd4) begin bad++; $display("FAIL flush_prefill_occ: got %0d want 4", oc4); end
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL flush_prefill_valid: got %0b want 1", ov4); end
    total++; if (do4 !== DW'(32'h10)) begin bad++; $display("FAIL flush_prefill_data: got %0h want 10", do4); end
    total++; if (co4 !== 16'h0001) begin bad++; $display("FAIL flush_prefill_ctrl: got %0h want 1", co4); end
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; ctrl_in = 16'hFFFF; data_in = DW'(32'h99);
    tick();
    total++; if (oc4 !== 3'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", oc4); end
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", ov4); end
    total++; if (co4 !== '0) begin bad++; $display("FAIL flush_ctrl: got %0h want 0", co4); end
    total++; if (do4 !== DW'(32'h10)) begin bad++; $display("FAIL flush_data_held: got %0h want 10", do4); end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; ctrl_in = '0; data_in = '0;
    // The slot presented during the flush must never emerge.
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (ov4 !== 1'b0 || co4 !== '0) begin bad++; $display("FAIL flush_discard[%0d]: got v=%0b c=%0h want v=0 c=0", c, ov4, co4); end
    end
  endtask

  // Bubbles carrying all-ones control must never expose it.
  task automatic test_bubble_safety();
    do_reset();
    in_valid = 1'b0; ctrl_in = 16'hFFFF;
    for (int c = 0; c < 6; c++) begin
      data_in = DW'(32'hC0DE_0000 + c);
      tick();
      total++; if ({co2, co3, co4} !== '0) begin bad++; $display("FAIL bubble_ctrl[%0d]: got %0h/%0h/%0h want 0", c, co2, co3, co4); end
      total++; if ({ov2, ov3, ov4} !== 3'b000) begin bad++; $display("FAIL bubble_valid[%0d]: got %0b%0b%0b want 000", c, ov2, ov3, ov4); end
    end
    ctrl_in = '0; data_in = '0;
  endtask

`ifdef EX_PIPE_REG_PERF_EN
  task automatic test_perf();
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    flush = 1'b1;
    tick();
    total++; if (sc2 !== 32'd5) begin bad++; $display("FAIL perf_stall_cnt: got %0d want 5", sc2); end
    total++; if (bc2 !== 32'd6) begin bad++; $display("FAIL perf_bubble_cnt: got %0d want 6", bc2); end
    stall = 1'b0; flush = 1'b0;
    force u_d2.stall_cnt = 32'hFFFF_FFFE;
    tick();
    release u_d2.stall_cnt;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    total++; if (sc2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL perf_stall_sat: got %0h want ffffffff", sc2); end
    stall = 1'b0;
  endtask
`endif

  initial begin
    RESET = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; ctrl_in = '0; data_in = '0;
    test_reset();
    test_reset_priority();
    test_latency();
    test_stall();
    test_flush_vs_stall();
    test_bubble_safety();
`ifdef EX_PIPE_REG_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
